// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - request/response sequencer that drives an external ALU
//
// Purpose: accepts one ALU request at a time, presents its operands to the ALU
// for a DRIVE cycle (optionally writing flags) and a CAPT cycle, captures the
// result and flags, evaluates a condition on them, and holds the response until
// the consumer accepts it. Counts completed responses.
//
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   req_valid_i / req_ready_o       request handshake
//   req_fun_sel_i, req_a_i, req_b_i request function code and operands
//   req_wf_i, req_cond_i            flag write enable, condition select
//   alu_a_o, alu_b_o, alu_fun_sel_o operands and function code to the ALU
//   alu_wf_o                        flag write enable to the ALU
//   alu_out_i, alu_flags_i          ALU result and registered flags {O,N,C,Z}
//   rsp_valid_o / rsp_ready_i       response handshake
//   rsp_data_o, rsp_flags_o         captured result and flags
//   rsp_cond_true_o                 latched condition evaluated on rsp_flags_o
//   op_count_o                      completed responses, wrapping

module alu_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [4:0]       req_fun_sel_i,
  input  logic [31:0]      req_a_i,
  input  logic [31:0]      req_b_i,
  input  logic             req_wf_i,
  input  logic [2:0]       req_cond_i,
  output logic [31:0]      alu_a_o,
  output logic [31:0]      alu_b_o,
  output logic [4:0]       alu_fun_sel_o,
  output logic             alu_wf_o,
  input  logic [31:0]      alu_out_i,
  input  logic [3:0]       alu_flags_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_data_o,
  output logic [3:0]       rsp_flags_o,
  output logic             rsp_cond_true_o,
  output logic [CNT_W-1:0] op_count_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e           state_q;
  logic [31:0]      alu_a_q;
  logic [31:0]      alu_b_q;
  logic [4:0]       alu_fun_q;
  logic             alu_wf_q;
  logic [2:0]       cond_q;
  logic [31:0]      rsp_data_q;
  logic [3:0]       rsp_flags_q;
  logic             rsp_cond_q;
  logic [CNT_W-1:0] op_count_q;
  logic             cond_true_d;

  // Condition evaluated on the flags the ALU presents during CAPT, so the
  // latched result lines up with the latched flags.
  always_comb begin
    cond_true_d = 1'b0;
    case (cond_q)
      3'b000:  cond_true_d = 1'b1;
      3'b001:  cond_true_d = alu_flags_i[0];
      3'b010:  cond_true_d = ~alu_flags_i[0];
      3'b011:  cond_true_d = alu_flags_i[1];
      3'b100:  cond_true_d = ~alu_flags_i[1];
      3'b101:  cond_true_d = alu_flags_i[2];
      3'b110:  cond_true_d = ~alu_flags_i[2];
      default: cond_true_d = alu_flags_i[3];
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= '0;
      alu_wf_q    <= 1'b0;
      cond_q      <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_cond_q  <= 1'b0;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            // ALU drive values are loaded here so they are already valid
            // during the whole DRIVE cycle.
            alu_a_q   <= req_a_i;
            alu_b_q   <= req_b_i;
            alu_fun_q <= req_fun_sel_i;
            alu_wf_q  <= req_wf_i;
            cond_q    <= req_cond_i;
            state_q   <= DRIVE;
          end
        end
        DRIVE: begin
          alu_wf_q <= 1'b0;
          state_q  <= CAPT;
        end
        CAPT: begin
          rsp_data_q  <= alu_out_i;
          rsp_flags_q <= alu_flags_i;
          rsp_cond_q  <= cond_true_d;
          // Operands stay put; only the function code is parked at zero.
          alu_fun_q   <= '0;
          state_q     <= RESP;
        end
        default: begin
          if (rsp_ready_i) begin
            op_count_q <= op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            state_q    <= IDLE;
          end
        end
      endcase
    end
  end

  assign req_ready_o     = (state_q == IDLE);
  assign rsp_valid_o     = (state_q == RESP);
  assign alu_a_o         = alu_a_q;
  assign alu_b_o         = alu_b_q;
  assign alu_fun_sel_o   = alu_fun_q;
  assign alu_wf_o        = alu_wf_q;
  assign rsp_data_o      = rsp_data_q;
  assign rsp_flags_o     = rsp_flags_q;
  assign rsp_cond_true_o = rsp_cond_q;
  assign op_count_o      = op_count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with an ALU stub

module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_fun_sel;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_wf;
  logic [2:0]  req_cond;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_fun_sel;
  logic        alu_wf;
  logic [31:0] alu_out;
  logic [3:0]  alu_flags = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_flags;
  logic        rsp_cond_true;
  logic [7:0]  op_count;

  int vectors = 0;
  int miscompares = 0;
  int wf_cycles = 0;
  int overlap_cycles = 0;

  logic [31:0] exp_data;
  logic [3:0]  exp_flags = 4'h0;
  logic        exp_cond;
  logic [7:0]  exp_count = 8'd0;
  logic [31:0] exp_a;
  logic [31:0] exp_b;

  always #5 clk = ~clk;

  alu_sequencer #(.CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_fun_sel_i(req_fun_sel), .req_a_i(req_a), .req_b_i(req_b),
    .req_wf_i(req_wf), .req_cond_i(req_cond),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_fun_sel_o(alu_fun_sel), .alu_wf_o(alu_wf),
    .alu_out_i(alu_out), .alu_flags_i(alu_flags),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_flags_o(rsp_flags), .rsp_cond_true_o(rsp_cond_true),
    .op_count_o(op_count)
  );

  // Reference ALU: returns {O,N,C,Z, result}. Low nibble of the function code
  // picks the operation, bit 4 picks 32-bit (1) or 16-bit (0) width.
  function automatic logic [35:0] alu_fn(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic c, o, n;
    s = 33'd0; c = 1'b0; o = 1'b0;
    case (f[3:0])
      4'b0100: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; o = (a[31] == b[31]) && (r[31] != a[31]); end
      4'b0110: begin s = {1'b0, a} - {1'b0, b}; r = s[31:0]; c = s[32]; o = (a[31] != b[31]) && (r[31] != a[31]); end
      4'b1100: r = a | b;
      4'b1000: r = a & b;
      4'b1110: r = a ^ b;
      default: r = a;
    endcase
    if (!f[4]) begin
      r = {16'h0000, r[15:0]};
      c = 1'b0;
      o = 1'b0;
      n = r[15];
    end else begin
      n = r[31];
    end
    return {o, n, c, (r == 32'd0), r};
  endfunction

  function automatic logic cond_eval(input logic [2:0] c, input logic [3:0] f);
    logic o, n, cy, z;
    {o, n, cy, z} = f;
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return cy;
      3'd4: return !cy;
      3'd5: return n;
      3'd6: return !n;
      default: return o;
    endcase
  endfunction

  // ALU stub: combinational result, flags registered when the write enable is up.
  assign alu_out = alu_fn(alu_fun_sel, alu_a, alu_b)[31:0];
  always @(posedge clk) if (alu_wf) alu_flags <= alu_fn(alu_fun_sel, alu_a, alu_b)[35:32];

  always @(negedge clk) begin
    if (alu_wf) wf_cycles <= wf_cycles + 1;
    if (rsp_valid && req_ready) overlap_cycles <= overlap_cycles + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a request at the current negedge and follows it through
  // DRIVE, CAPT and into RESP, checking the ALU drive and the response.
  task automatic start_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic wf, input logic [2:0] c);
    logic [35:0] r;
    int w0;
    r = alu_fn(f, a, b);
    if (wf) exp_flags = r[35:32];
    exp_data = r[31:0];
    exp_cond = cond_eval(c, exp_flags);
    exp_a = a;
    exp_b = b;
    w0 = wf_cycles;
    req_valid = 1'b1; req_fun_sel = f; req_a = a; req_b = b; req_wf = wf; req_cond = c;
    chk("idle_ready", req_ready, 1);
    @(negedge clk);
    // Garbage while busy must be ignored.
    req_fun_sel = 5'($urandom); req_a = $urandom; req_b = $urandom;
    req_wf = 1'($urandom); req_cond = 3'($urandom);
    chk("drive_ready", req_ready, 0);
    chk("drive_rsp_valid", rsp_valid, 0);
    chk("drive_alu_a", alu_a, a);
    chk("drive_alu_b", alu_b, b);
    chk("drive_fun", alu_fun_sel, f);
    chk("drive_wf", alu_wf, wf);
    @(negedge clk);
    chk("capt_fun", alu_fun_sel, f);
    chk("capt_wf", alu_wf, 0);
    chk("capt_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("resp_valid", rsp_valid, 1);
    chk("resp_ready", req_ready, 0);
    chk("resp_data", rsp_data, exp_data);
    chk("resp_flags", rsp_flags, exp_flags);
    chk("resp_cond", rsp_cond_true, exp_cond);
    chk("resp_fun_idle", alu_fun_sel, 0);
    chk("resp_alu_a_hold", alu_a, a);
    chk("wf_cycles", wf_cycles - w0, wf ? 1 : 0);
  endtask

  task automatic finish_op(input int stall);
    rsp_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_ready", req_ready, 0);
      chk("stall_data", rsp_data, exp_data);
      chk("stall_flags", rsp_flags, exp_flags);
      chk("stall_count", op_count, exp_count);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_count = exp_count + 8'd1;
    chk("done_ready", req_ready, 1);
    chk("done_valid", rsp_valid, 0);
    chk("done_count", op_count, exp_count);
  endtask

  task automatic random_op(input int max_stall);
    logic [4:0] f;
    case ($urandom_range(0, 5))
      0: f[3:0] = 4'b0100;
      1: f[3:0] = 4'b0110;
      2: f[3:0] = 4'b1100;
      3: f[3:0] = 4'b1000;
      4: f[3:0] = 4'b1110;
      default: f[3:0] = 4'b0000;
    endcase
    f[4] = 1'($urandom);
    start_op(f, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
             1'($urandom), 3'($urandom));
    finish_op($urandom_range(0, max_stall));
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_fun_sel = '0; req_a = '0; req_b = '0; req_wf = 1'b0; req_cond = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_flags", rsp_flags, 0);
    chk("rst_cond", rsp_cond_true, 0);
    chk("rst_count", op_count, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_fun", alu_fun_sel, 0);
    chk("rst_wf", alu_wf, 0);

    // Add 5+3 with flag write.
    start_op(5'b10100, 32'h5, 32'h3, 1'b1, 3'b000);
    chk("add_data", rsp_data, 32'h8);
    chk("add_z", rsp_flags[0], 0);
    chk("add_cond", rsp_cond_true, 1);
    finish_op(0);
    chk("add_count", op_count, 1);

    // Equal subtract sets Z; held under 5 cycles of backpressure.
    start_op(5'b10110, 32'h1234, 32'h1234, 1'b1, 3'b001);
    chk("sub_data", rsp_data, 0);
    chk("sub_z", rsp_flags[0], 1);
    chk("sub_cond", rsp_cond_true, 1);
    finish_op(5);
    chk("sub_count", op_count, 2);

    // OR without flag write keeps Z from the subtract.
    start_op(5'b11100, 32'h1, 32'h2, 1'b0, 3'b010);
    chk("or_data", rsp_data, 3);
    chk("or_z", rsp_flags[0], 1);
    chk("or_cond", rsp_cond_true, 0);
    finish_op(1);

    for (int i = 0; i < 24; i++) random_op(3);

    // Reset while in DRIVE discards the request.
    req_valid = 1'b1; req_fun_sel = 5'b10100; req_a = 32'h77; req_b = 32'h1;
    req_wf = 1'b1; req_cond = 3'b000;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rd_wf", alu_wf, 1);
    exp_flags = alu_fn(5'b10100, 32'h77, 32'h1)[35:32];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_count = 8'd0;
    chk("rd_ready", req_ready, 1);
    chk("rd_valid", rsp_valid, 0);
    chk("rd_count", op_count, 0);
    chk("rd_wf_low", alu_wf, 0);
    chk("rd_alu_a", alu_a, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rd_no_rsp", rsp_valid, 0);
    end

    // Reset beats a simultaneous response handshake.
    start_op(5'b11110, 32'hF0F0, 32'h0FF0, 1'b1, 3'b011);
    rsp_ready = 1'b1; rst = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0; rst = 1'b0;
    chk("rr_count", op_count, 0);
    chk("rr_valid", rsp_valid, 0);
    chk("rr_data", rsp_data, 0);

    // Reset beats a simultaneous request handshake.
    req_valid = 1'b1; req_a = 32'hDEAD; rst = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b0;
    chk("rq_ready", req_ready, 1);
    chk("rq_alu_a", alu_a, 0);

    // 256 completions wrap the counter back to zero.
    for (int i = 0; i < 256; i++) random_op(1);
    chk("wrap_count", op_count, 0);
    chk("no_overlap", overlap_cycles, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
